jb_pa_power_seq: RTL and testbench
==================================

JB_PA_POWER_SEQ -- requirements
Module: jb_pa_power_seq

Interface
REQ-001 SHALL have parameter N_ANTENNAS, default 4, meaning PA channel count (even, ≥2); pair count is N_ANTENNAS/2.
REQ-002 SHALL have parameter CNT_W, default 24, meaning timer width in bits.
REQ-003 SHALL use a single clock: axi_clk  input  1  clocks all logic.
REQ-004 SHALL have reset axi_resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have seq_enable  input  1  power-on request (level).
REQ-006 SHALL have ant_enable  input  N_ANTENNAS  per-antenna enable mask.
REQ-007 SHALL have t_settle  input  CNT_W  inter-step delay in cycles; 0 is treated as 1.
REQ-008 SHALL have t_pgood_to  input  CNT_W  pgood timeout in cycles.
REQ-009 SHALL have pa_v_pgood  input  1  28V brick power-good, synchronous to axi_clk.
REQ-010 SHALL have pa_fault  input  N_ANTENNAS  per-antenna overdrive fault pulses.
REQ-011 SHALL have fault_clr  input  1  fault clear request.
REQ-012 SHALL have pa_v_en_n  output  1  brick enable, active-low.
REQ-013 SHALL have pa_dc_sw  output  N_ANTENNAS/2  per-pair drain switch enable.
REQ-014 SHALL have pa_ctrl_sleep  output  N_ANTENNAS  per-antenna sleep, where 1 = asleep.
REQ-015 SHALL have seq_state  output  3  current state encoding.
REQ-016 SHALL have the following status outputs:
- seq_busy  output  1
- fault_latched  output  N_ANTENNAS  (sticky)
- pgood_timeout  output  1  (sticky)
- irq  output  1  (pulse)

Function
REQ-017 States and encodings SHALL be: OFF=0, WAIT_PGOOD=1, DC_ON=2, WAKE=3, ON=4, SLEEP_DN=5, DC_OFF=6, FAULT=7.
REQ-018 All outputs SHALL be registered and reflect a state change one cycle after the transition.
REQ-019 Safe output set: pa_v_en_n=1, pa_dc_sw=0, pa_ctrl_sleep=all 1s.
- OFF and FAULT SHALL drive the safe set.
REQ-020 OFF→WAIT_PGOOD SHALL occur when seq_enable=1, fault_latched=0 and pgood_timeout=0.
- ant_enable SHALL be captured into an internal mask on this transition.
- Later ant_enable changes SHALL be ignored until the next OFF exit.
REQ-021 WAIT_PGOOD SHALL:
- drive pa_v_en_n=0 and run a timer from 0;
- go to DC_ON when pa_v_pgood is accepted;
- on timer reaching t_pgood_to first, set pgood_timeout and go to FAULT.
REQ-022 DC_ON SHALL set pa_dc_sw[p]=1 for each pair p with any captured-enabled antenna, wait t_settle cycles, then go to WAKE.
REQ-023 WAKE SHALL scan antenna index i from 0 upward:
- enabled antenna: clear pa_ctrl_sleep[i], then wait t_settle cycles;
- disabled antenna: advance in one cycle;
- after index N_ANTENNAS-1, go to ON.
REQ-024 ON SHALL hold outputs. seq_enable=0 SHALL go to SLEEP_DN; loss of accepted pa_v_pgood SHALL go to FAULT.
REQ-025 SLEEP_DN SHALL drive pa_ctrl_sleep all 1s, wait t_settle cycles, then go to DC_OFF.
REQ-026 DC_OFF SHALL drive pa_dc_sw=0, wait t_settle cycles, then drive pa_v_en_n=1 and go to OFF.
REQ-027 seq_enable=0 during WAIT_PGOOD, DC_ON or WAKE SHALL go to SLEEP_DN.
REQ-028 pa_fault[i]=1 in any state SHALL set fault_latched[i].
- In DC_ON, WAKE or ON, it SHALL also force FAULT.
- Fault SHALL take priority over seq_enable and pgood events in the same cycle.
REQ-029 FAULT SHALL exit to OFF only when fault_clr=1 and seq_enable=0 in the same cycle; that transition SHALL clear fault_latched and pgood_timeout.
REQ-030 seq_busy SHALL be 1 in states 1, 2, 3, 5 and 6.
REQ-031 irq SHALL pulse for one cycle on entry to ON, on entry to FAULT, and on DC_OFF→OFF.
REQ-032 Timers SHALL be unsigned CNT_W bits and compare with ≥; they SHALL NOT wrap, and SHALL saturate at all 1s.

Reset
REQ-033 While axi_resetn=0 at a clock edge, the next state SHALL be OFF.
REQ-034 Reset SHALL drive the safe output set, seq_state=0, seq_busy=0, fault_latched=0, pgood_timeout=0, irq=0, and clear timers and the captured mask.
REQ-035 Reset mid-sequence SHALL take effect at that edge with no orderly shutdown.

Configuration
REQ-036 With macro JB_PA_SEQ_PGOOD_DEBOUNCE_EN defined:
- pa_v_pgood SHALL be accepted only after 16 consecutive high samples;
- loss SHALL be declared only after 16 consecutive low samples in ON.
REQ-037 Without JB_PA_SEQ_PGOOD_DEBOUNCE_EN, a single sample SHALL decide both acceptance and loss.

Verification (N_ANTENNAS=4, t_settle=10, t_pgood_to=100, macro undefined)
REQ-038 Power-up with ant_enable=4'b1011 and pgood high 5 cycles after WAIT_PGOOD entry → pa_dc_sw=2'b11, then sleep bits for antennas 0, 1 and 3 clear 10 cycles apart, then ON with irq pulse.
REQ-039 pgood never asserted → FAULT 100 cycles after WAIT_PGOOD entry, with pgood_timeout=1, safe outputs and an irq pulse.
REQ-040 In ON, drop seq_enable → all sleep bits = 1, pa_dc_sw=0 10 cycles later, pa_v_en_n=1 and OFF 10 cycles after that, with an irq pulse.
REQ-041 pa_fault=4'b0100 in WAKE in the same cycle as seq_enable falls → FAULT with fault_latched=4'b0100; fault_clr with seq_enable=1 → FAULT is held; fault_clr with seq_enable=0 → OFF with fault_latched cleared.
REQ-042 axi_resetn low for 1 cycle during DC_ON → next cycle seq_state=0 with safe outputs.
REQ-043 With macro defined, a 15-cycle pgood low glitch in ON → state remains ON; a 16-cycle low → FAULT.

Source files
------------

// File: rtl/jb_pa_power_seq.sv
// PA power sequencer: 28V brick, per-pair drain switches and per-antenna sleep lines.
// Optional macro JB_PA_SEQ_PGOOD_DEBOUNCE_EN: pa_v_pgood accept/loss needs 16 consecutive samples.
module jb_pa_power_seq #(
  parameter int N_ANTENNAS = 4,
  parameter int CNT_W      = 24
) (
  input  logic                    axi_clk,
  input  logic                    axi_resetn,
  input  logic                    seq_enable,
  input  logic [N_ANTENNAS-1:0]   ant_enable,
  input  logic [CNT_W-1:0]        t_settle,
  input  logic [CNT_W-1:0]        t_pgood_to,
  input  logic                    pa_v_pgood,
  input  logic [N_ANTENNAS-1:0]   pa_fault,
  input  logic                    fault_clr,
  output logic                    pa_v_en_n,
  output logic [N_ANTENNAS/2-1:0] pa_dc_sw,
  output logic [N_ANTENNAS-1:0]   pa_ctrl_sleep,
  output logic [2:0]              seq_state,
  output logic                    seq_busy,
  output logic [N_ANTENNAS-1:0]   fault_latched,
  output logic                    pgood_timeout,
  output logic                    irq
);
  localparam int N_PAIRS = N_ANTENNAS / 2;
  localparam int IDX_W   = $clog2(N_ANTENNAS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ANTENNAS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_WAIT_PGOOD = 3'd1,
    S_DC_ON      = 3'd2,
    S_WAKE       = 3'd3,
    S_ON         = 3'd4,
    S_SLEEP_DN   = 3'd5,
    S_DC_OFF     = 3'd6,
    S_FAULT      = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_ANTENNAS-1:0]   mask_q, mask_d;
  logic [N_ANTENNAS-1:0]   flt_q, flt_d;
  logic                    pgto_q, pgto_d;
  logic                    ven_n_q, ven_n_d;
  logic [N_PAIRS-1:0]      dc_q, dc_d;
  logic [N_ANTENNAS-1:0]   sleep_q, sleep_d;
  logic                    busy_q, busy_d;
  logic                    irq_q, irq_d;

  logic [CNT_W-1:0]        timer_inc, settle_eff;
  logic                    settle_done, any_fault, pg_ok, pg_lost;
  logic [N_PAIRS-1:0]      pair_en;

`ifdef JB_PA_SEQ_PGOOD_DEBOUNCE_EN
  logic [4:0] pg_hi_q, pg_hi_d, pg_lo_q, pg_lo_d;

  // Consecutive high / low (in ON only) sample counters, saturating at 16
  always_comb begin
    pg_hi_d = 5'd0;
    pg_lo_d = 5'd0;
    if (pa_v_pgood) begin
      pg_hi_d = (pg_hi_q == 5'd16) ? pg_hi_q : pg_hi_q + 5'd1;
    end else begin
      pg_hi_d = 5'd0;
    end
    if (!pa_v_pgood && (state_q == S_ON)) begin
      pg_lo_d = (pg_lo_q == 5'd16) ? pg_lo_q : pg_lo_q + 5'd1;
    end else begin
      pg_lo_d = 5'd0;
    end
  end

  // Debounce counter registers
  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      pg_hi_q <= 5'd0;
      pg_lo_q <= 5'd0;
    end else begin
      pg_hi_q <= pg_hi_d;
      pg_lo_q <= pg_lo_d;
    end
  end

  // The current sample is the 16th when 15 are already counted
  assign pg_ok   = pa_v_pgood && (pg_hi_q >= 5'd15);
  assign pg_lost = !pa_v_pgood && (pg_lo_q >= 5'd15);
`else
  assign pg_ok   = pa_v_pgood;
  assign pg_lost = !pa_v_pgood;
`endif

  // Timer, settle and pair-enable helpers
  always_comb begin
    timer_inc   = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_ONE;
    settle_eff  = (t_settle == {CNT_W{1'b0}}) ? CNT_ONE : t_settle;
    settle_done = (timer_inc >= settle_eff);
    any_fault   = |pa_fault;
    for (int p = 0; p < N_PAIRS; p++) begin
      pair_en[p] = mask_q[2*p] | mask_q[2*p+1];
    end
  end

  // Next-state, timer, scan index and sticky status logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    idx_d   = idx_q;
    mask_d  = mask_q;
    flt_d   = flt_q | pa_fault;
    pgto_d  = pgto_q;
    case (state_q)
      S_OFF: begin
        if (seq_enable && (flt_q == {N_ANTENNAS{1'b0}}) && !pgto_q) begin
          state_d = S_WAIT_PGOOD;
          mask_d  = ant_enable;
        end else begin
          state_d = S_OFF;
        end
      end
      S_WAIT_PGOOD: begin
        if (!seq_enable) begin
          state_d = S_SLEEP_DN;
        end else if (pg_ok) begin
          state_d = S_DC_ON;
        end else if (timer_inc >= t_pgood_to) begin
          state_d = S_FAULT;
          pgto_d  = 1'b1;
        end else begin
          state_d = S_WAIT_PGOOD;
        end
      end
      S_DC_ON: begin
        if (any_fault) begin
          state_d = S_FAULT;
        end else if (!seq_enable) begin
          state_d = S_SLEEP_DN;
        end else if (settle_done) begin
          state_d = S_WAKE;
        end else begin
          state_d = S_DC_ON;
        end
      end
      S_WAKE: begin
        if (any_fault) begin
          state_d = S_FAULT;
        end else if (!seq_enable) begin
          state_d = S_SLEEP_DN;
        end else if (!mask_q[idx_q] || settle_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_ON;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            timer_d = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_WAKE;
        end
      end
      S_ON: begin
        if (any_fault || pg_lost) begin
          state_d = S_FAULT;
        end else if (!seq_enable) begin
          state_d = S_SLEEP_DN;
        end else begin
          state_d = S_ON;
        end
      end
      S_SLEEP_DN: begin
        state_d = settle_done ? S_DC_OFF : S_SLEEP_DN;
      end
      S_DC_OFF: begin
        state_d = settle_done ? S_OFF : S_DC_OFF;
      end
      S_FAULT: begin
        if (fault_clr && !seq_enable) begin
          state_d = S_OFF;
          flt_d   = pa_fault;
          pgto_d  = 1'b0;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: state_d = S_OFF;
    endcase
    if (state_d != state_q) begin
      timer_d = {CNT_W{1'b0}};
      idx_d   = {IDX_W{1'b0}};
    end else begin
      idx_d = idx_d;
    end
  end

  // Output values for the state being entered; registered so they track state_q
  always_comb begin
    ven_n_d = 1'b1;
    dc_d    = {N_PAIRS{1'b0}};
    sleep_d = {N_ANTENNAS{1'b1}};
    busy_d  = 1'b0;
    case (state_d)
      S_WAIT_PGOOD: begin
        ven_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      S_DC_ON: begin
        ven_n_d = 1'b0;
        dc_d    = pair_en;
        busy_d  = 1'b1;
      end
      S_WAKE: begin
        ven_n_d = 1'b0;
        dc_d    = pair_en;
        busy_d  = 1'b1;
        for (int j = 0; j < N_ANTENNAS; j++) begin
          if (mask_q[j] && (IDX_W'(j) <= idx_d)) begin
            sleep_d[j] = 1'b0;
          end else begin
            sleep_d[j] = 1'b1;
          end
        end
      end
      S_ON: begin
        ven_n_d = 1'b0;
        dc_d    = pair_en;
        sleep_d = ~mask_q;
      end
      S_SLEEP_DN: begin
        // Hold drains as they were: an early abort must not switch them on
        ven_n_d = 1'b0;
        dc_d    = dc_q;
        busy_d  = 1'b1;
      end
      S_DC_OFF: begin
        ven_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      default: begin
        ven_n_d = 1'b1;
      end
    endcase
    irq_d = ((state_d == S_ON) && (state_q != S_ON)) ||
            ((state_d == S_FAULT) && (state_q != S_FAULT)) ||
            ((state_q == S_DC_OFF) && (state_d == S_OFF));
  end

  // State and output registers
  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q <= S_OFF;
      timer_q <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      mask_q  <= {N_ANTENNAS{1'b0}};
      flt_q   <= {N_ANTENNAS{1'b0}};
      pgto_q  <= 1'b0;
      ven_n_q <= 1'b1;
      dc_q    <= {N_PAIRS{1'b0}};
      sleep_q <= {N_ANTENNAS{1'b1}};
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      flt_q   <= flt_d;
      pgto_q  <= pgto_d;
      ven_n_q <= ven_n_d;
      dc_q    <= dc_d;
      sleep_q <= sleep_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
    end
  end

  assign pa_v_en_n     = ven_n_q;
  assign pa_dc_sw      = dc_q;
  assign pa_ctrl_sleep = sleep_q;
  assign seq_state     = state_q;
  assign seq_busy      = busy_q;
  assign fault_latched = flt_q;
  assign pgood_timeout = pgto_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_jb_pa_power_seq.sv
// Scoreboard bench for jb_pa_power_seq: expected output snapshots are queued with the
// cycle they are due when stimulus is driven, and compared as that cycle is reached.
`timescale 1ns/1ps
module tb_jb_pa_power_seq;
`ifdef JB_PA_SEQ_PGOOD_DEBOUNCE_EN
  localparam int ACC = 15;
`else
  localparam int ACC = 0;
`endif
  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        axi_resetn, seq_enable, pa_v_pgood, fault_clr;
  logic [3:0]  ant_enable, pa_fault;
  logic [23:0] t_settle, t_pgood_to;
  logic        pa_v_en_n, seq_busy, pgood_timeout, irq;
  logic [1:0]  pa_dc_sw;
  logic [3:0]  pa_ctrl_sleep, fault_latched;
  logic [2:0]  seq_state;

  jb_pa_power_seq #(.N_ANTENNAS(4), .CNT_W(24)) dut (
    .axi_clk(clk), .axi_resetn(axi_resetn), .seq_enable(seq_enable),
    .ant_enable(ant_enable), .t_settle(t_settle), .t_pgood_to(t_pgood_to),
    .pa_v_pgood(pa_v_pgood), .pa_fault(pa_fault), .fault_clr(fault_clr),
    .pa_v_en_n(pa_v_en_n), .pa_dc_sw(pa_dc_sw), .pa_ctrl_sleep(pa_ctrl_sleep),
    .seq_state(seq_state), .seq_busy(seq_busy), .fault_latched(fault_latched),
    .pgood_timeout(pgood_timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; string tag; logic [16:0] v; } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int n_checks = 0;
  int n_errors = 0;
  int b;
  logic [16:0] obs_v;
  assign obs_v = {seq_state, pa_v_en_n, pa_dc_sw, pa_ctrl_sleep, seq_busy,
                  fault_latched, pgood_timeout, irq};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [16:0] mk(input logic [2:0] st, input logic ven, input logic [1:0] dc,
                                     input logic [3:0] sl, input logic busy, input logic [3:0] flt,
                                     input logic pgto, input logic irq_e);
    return {st, ven, dc, sl, busy, flt, pgto, irq_e};
  endfunction

  task automatic push(input string tag, input int d, input logic [16:0] v);
    exp_t e;
    e.at = cyc + d; e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      step(1);
      k++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Compare every snapshot due at this cycle, away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e_mon = sb.pop_front();
      check_eq(e_mon.tag, {15'd0, obs_v}, {15'd0, e_mon.v});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    axi_resetn = 1'b0; seq_enable = 1'b0; ant_enable = 4'h0; pa_fault = 4'h0;
    t_settle = 24'd10; t_pgood_to = 24'd100; pa_v_pgood = 1'b0; fault_clr = 1'b0;
    step(2);
    push("reset", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);
    axi_resetn = 1'b1;

    // Power-up with mask 1011, pgood arriving 5 cycles after WAIT_PGOOD entry
    ant_enable = 4'b1011; seq_enable = 1'b1;
    push("pu_wait", 1, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("pu_wait_hold", 5, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    step(5);
    ant_enable = 4'b0000;
    pa_v_pgood = 1'b1;
    b = 1 + ACC;
    push("dc_on", b, mk(3'd2, 1'b0, 2'b11, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("dc_on_hold", b + 9, mk(3'd2, 1'b0, 2'b11, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a0", b + 10, mk(3'd3, 1'b0, 2'b11, 4'b1110, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a0_hold", b + 19, mk(3'd3, 1'b0, 2'b11, 4'b1110, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a1", b + 20, mk(3'd3, 1'b0, 2'b11, 4'b1100, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a2_skip", b + 30, mk(3'd3, 1'b0, 2'b11, 4'b1100, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a3", b + 31, mk(3'd3, 1'b0, 2'b11, 4'b0100, 1'b1, 4'h0, 1'b0, 1'b0));
    push("wake_a3_hold", b + 40, mk(3'd3, 1'b0, 2'b11, 4'b0100, 1'b1, 4'h0, 1'b0, 1'b0));
    push("on_irq", b + 41, mk(3'd4, 1'b0, 2'b11, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b1));
    push("on_hold", b + 42, mk(3'd4, 1'b0, 2'b11, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b0));
    drain(200);

    // Orderly power-down from ON
    seq_enable = 1'b0;
    push("sdn", 1, mk(3'd5, 1'b0, 2'b11, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("sdn_hold", 10, mk(3'd5, 1'b0, 2'b11, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("dcoff", 11, mk(3'd6, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("dcoff_hold", 20, mk(3'd6, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("off_irq", 21, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b1));
    push("off_idle", 22, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    drain(100);

    // pgood never arrives: timeout into FAULT, then clear
    pa_v_pgood = 1'b0; ant_enable = 4'b1011; seq_enable = 1'b1;
    push("to_wait", 1, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("to_wait_hold", 100, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("to_fault", 101, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b1, 1'b1));
    push("to_fault_hold", 102, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b1, 1'b0));
    drain(200);
    fault_clr = 1'b1;
    push("to_clr_blocked", 1, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b1, 1'b0));
    step(1);
    seq_enable = 1'b0;
    push("to_clr", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);
    fault_clr = 1'b0;

    // Fault in WAKE coinciding with seq_enable falling
    pa_v_pgood = 1'b1; ant_enable = 4'b1111;
    step(20);
    seq_enable = 1'b1;
    push("f_wait", 1, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("f_dcon", 2, mk(3'd2, 1'b0, 2'b11, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("f_wake", 12, mk(3'd3, 1'b0, 2'b11, 4'b1110, 1'b1, 4'h0, 1'b0, 1'b0));
    drain(40);
    step(3);
    pa_fault = 4'b0100; seq_enable = 1'b0;
    push("f_fault", 1, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'b0100, 1'b0, 1'b1));
    push("f_fault_hold", 2, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'b0100, 1'b0, 1'b0));
    step(1);
    pa_fault = 4'h0;
    drain(10);
    fault_clr = 1'b1; seq_enable = 1'b1;
    push("f_clr_blocked", 1, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'b0100, 1'b0, 1'b0));
    step(1);
    seq_enable = 1'b0;
    push("f_clr", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);
    fault_clr = 1'b0;

    // Reset pulse during DC_ON
    ant_enable = 4'b0001; seq_enable = 1'b1;
    push("r_wait", 1, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("r_dcon", 2, mk(3'd2, 1'b0, 2'b01, F, 1'b1, 4'h0, 1'b0, 1'b0));
    drain(10);
    step(3);
    axi_resetn = 1'b0;
    push("r_reset", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);
    axi_resetn = 1'b1; seq_enable = 1'b0;
    push("r_idle", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);

    // t_settle=0 behaves as 1; then loss of pgood in ON
    t_settle = 24'd0; ant_enable = 4'b0010; seq_enable = 1'b1;
    push("z_wait", 1, mk(3'd1, 1'b0, 2'b00, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("z_dcon", 2, mk(3'd2, 1'b0, 2'b01, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("z_wake0", 3, mk(3'd3, 1'b0, 2'b01, F, 1'b1, 4'h0, 1'b0, 1'b0));
    push("z_wake1", 4, mk(3'd3, 1'b0, 2'b01, 4'b1101, 1'b1, 4'h0, 1'b0, 1'b0));
    push("z_wake3", 6, mk(3'd3, 1'b0, 2'b01, 4'b1101, 1'b1, 4'h0, 1'b0, 1'b0));
    push("z_on", 7, mk(3'd4, 1'b0, 2'b01, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b1));
    push("z_on_hold", 8, mk(3'd4, 1'b0, 2'b01, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0));
    drain(20);
    pa_v_pgood = 1'b0;
    push("loss_fault", 1 + ACC, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b1));
    drain(40);
    seq_enable = 1'b0; fault_clr = 1'b1;
    push("loss_clr", 1, mk(3'd0, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b0));
    step(1);
    fault_clr = 1'b0;

`ifdef JB_PA_SEQ_PGOOD_DEBOUNCE_EN
    // 15-cycle pgood glitch is tolerated in ON, 16 cycles is a loss
    pa_v_pgood = 1'b1;
    step(20);
    seq_enable = 1'b1;
    push("g_on", 7, mk(3'd4, 1'b0, 2'b01, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b1));
    drain(20);
    pa_v_pgood = 1'b0;
    step(15);
    pa_v_pgood = 1'b1;
    push("g_glitch15", 2, mk(3'd4, 1'b0, 2'b01, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0));
    step(2);
    pa_v_pgood = 1'b0;
    push("g_loss16", 16, mk(3'd7, 1'b1, 2'b00, F, 1'b0, 4'h0, 1'b0, 1'b1));
    drain(40);
    seq_enable = 1'b0; fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
